// File: rtl/conv_window_gen.sv
// 3x3 sliding-window generator: buffers two image lines and emits one packed
// window per valid kernel position over an AXI-Stream style handshake.
module conv_window_gen #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 32,
  parameter int IMG_H  = 32
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic [DATA_W-1:0]     s_tdata,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  input  logic                  s_tuser,
  output logic [9*DATA_W-1:0]   m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  m_tlast,
  output logic                  frame_err
);

  localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  logic [COL_W-1:0]    col_q, col_d, eff_col;
  logic [ROW_W-1:0]    row_q, row_d, eff_row;
  logic                rdy_en_q;
  logic                accept, at_origin, sync_err, emit, last_pix;
  logic [DATA_W-1:0]   lb0_mem [IMG_W];
  logic [DATA_W-1:0]   lb1_mem [IMG_W];
  logic [DATA_W-1:0]   lb0_rd, lb1_rd;
  // Only the two older window columns are stored; the newest column comes
  // straight from the line-buffer reads and the incoming pixel.
  logic [DATA_W-1:0]   win_q [3][2];
  logic [9*DATA_W-1:0] win_next, mdata_q, mdata_d;
  logic                mvalid_q, mvalid_d, mlast_q, mlast_d, err_q, err_d;

  assign s_tready  = rdy_en_q && (!mvalid_q || m_tready);
  assign accept    = s_tvalid && s_tready;
  assign m_tdata   = mdata_q;
  assign m_tvalid  = mvalid_q;
  assign m_tlast   = mlast_q;
  assign frame_err = err_q;

  always_comb begin
    at_origin = (row_q == '0) && (col_q == '0);
    eff_row   = s_tuser ? '0 : row_q;
    eff_col   = s_tuser ? '0 : col_q;
    // A SOF away from the origin, or a missing SOF at the origin, is a sync error.
    sync_err  = s_tuser ? !at_origin : at_origin;
    last_pix  = (eff_row == ROW_W'(IMG_H - 1)) && (eff_col == COL_W'(IMG_W - 1));
    emit      = (eff_row >= ROW_W'(2)) && (eff_col >= COL_W'(2));
    lb0_rd    = lb0_mem[eff_col];
    lb1_rd    = lb1_mem[eff_col];
    win_next  = {s_tdata, win_q[2][1], win_q[2][0],
                 lb0_rd,  win_q[1][1], win_q[1][0],
                 lb1_rd,  win_q[0][1], win_q[0][0]};

    col_d    = col_q;
    row_d    = row_q;
    mdata_d  = mdata_q;
    mvalid_d = mvalid_q;
    mlast_d  = mlast_q;
    err_d    = 1'b0;

    if (accept) begin
      err_d = sync_err;
      if (eff_col == COL_W'(IMG_W - 1)) begin
        col_d = '0;
        row_d = (eff_row == ROW_W'(IMG_H - 1)) ? '0 : eff_row + ROW_W'(1);
      end else begin
        col_d = eff_col + COL_W'(1);
        row_d = eff_row;
      end
    end

    if (accept && emit) begin
      mdata_d  = win_next;
      mvalid_d = 1'b1;
      mlast_d  = last_pix;
    end else if (m_tready) begin
      mvalid_d = 1'b0;
      mlast_d  = 1'b0;
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      rdy_en_q <= 1'b0;
      col_q    <= '0;
      row_q    <= '0;
      mdata_q  <= '0;
      mvalid_q <= 1'b0;
      mlast_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      rdy_en_q <= 1'b1;
      col_q    <= col_d;
      row_q    <= row_d;
      mdata_q  <= mdata_d;
      mvalid_q <= mvalid_d;
      mlast_q  <= mlast_d;
      err_q    <= err_d;
    end
  end

  // Line memories and window columns hold pure data, so they carry no reset.
  always_ff @(posedge ACLK) begin
    if (accept) begin
      lb1_mem[eff_col] <= lb0_rd;
      lb0_mem[eff_col] <= s_tdata;
      win_q[0][0] <= win_q[0][1];
      win_q[0][1] <= lb1_rd;
      win_q[1][0] <= win_q[1][1];
      win_q[1][1] <= lb0_rd;
      win_q[2][0] <= win_q[2][1];
      win_q[2][1] <= s_tdata;
    end
  end

endmodule

// File: tb/tb_conv_window_gen.sv
// Directed bench for conv_window_gen on a 4x4 image: windows are captured into
// a queue and compared against hand-computed pixel positions.
module tb_conv_window_gen;

  localparam int DW = 8;
  localparam int W  = 4;
  localparam int H  = 4;

  logic            aclk = 1'b0;
  logic            areset;
  logic [DW-1:0]   sTdata;
  logic            sTvalid, sTready, sTuser;
  logic [9*DW-1:0] mTdata;
  logic            mTvalid, mTready, mTlast, frameErr;

  int   checks = 0;
  int   errors = 0;
  int   errPulses = 0;
  bit   rndMode = 1'b0;
  logic [9*DW:0] winQ[$];

  always #5 aclk = ~aclk;

  conv_window_gen #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) dut (
    .ACLK(aclk), .ARESET(areset),
    .s_tdata(sTdata), .s_tvalid(sTvalid), .s_tready(sTready), .s_tuser(sTuser),
    .m_tdata(mTdata), .m_tvalid(mTvalid), .m_tready(mTready), .m_tlast(mTlast),
    .frame_err(frameErr)
  );

  // Handshakes are sampled mid-low-phase, after inputs settle and before the edge.
  always begin
    @(negedge aclk);
    #2;
    if (!areset && mTvalid && mTready) winQ.push_back({mTlast, mTdata});
    if (!areset && frameErr) errPulses++;
  end

  initial begin
    #200000;
    $display("[TB] FAIL globalTimeout observed=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

  function automatic logic [9*DW-1:0] packWin(input int base, input int r, input int c);
    logic [9*DW-1:0] w;
    int p;
    w = '0;
    for (int k = 0; k < 9; k++) begin
      p = base + (r - 2 + k / 3) * W + (c - 2 + k % 3);
      w[DW*k +: DW] = DW'(p);
    end
    return w;
  endfunction

  task automatic checkOutput(input string tag, input logic [9*DW:0] obs, input logic [9*DW:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [DW-1:0] d, input logic u);
    int guard;
    if (rndMode) begin
      repeat ($urandom_range(0, 2)) begin
        sTvalid = 1'b0;
        mTready = 1'($urandom_range(0, 1));
        @(negedge aclk);
      end
      mTready = 1'($urandom_range(0, 1));
    end
    sTdata = d;
    sTuser = u;
    sTvalid = 1'b1;
    guard = 0;
    #1;
    while (sTready !== 1'b1 && guard < 200) begin
      @(negedge aclk);
      guard++;
      if (rndMode) mTready = 1'($urandom_range(0, 1));
      #1;
    end
    if (guard >= 200) checkOutput("acceptTimeout", 73'(guard), 73'(0));
    @(negedge aclk);
    sTvalid = 1'b0;
    sTuser = 1'b0;
  endtask

  task automatic sendFrame(input int base, input logic withSof);
    for (int i = 0; i < W * H; i++) applyStimulus(DW'(base + i), withSof && (i == 0));
  endtask

  task automatic drain(input int n);
    mTready = 1'b1;
    sTvalid = 1'b0;
    repeat (n) @(negedge aclk);
  endtask

  task automatic checkWindows(input string tag, input int base, input int idx);
    logic [9*DW:0] obs;
    for (int i = 0; i < 4; i++) begin
      obs = (idx + i < winQ.size()) ? winQ[idx + i] : 'x;
      checkOutput($sformatf("%s_win%0d", tag, i), obs, {(i == 3), packWin(base, 2 + i / 2, 2 + i % 2)});
    end
  endtask

  initial begin
    int b, e;
    areset = 1'b1;
    sTvalid = 1'b0;
    sTuser = 1'b0;
    sTdata = '0;
    mTready = 1'b1;
    repeat (2) @(negedge aclk);
    #1;
    checkOutput("rstSReady", 73'(sTready), 73'(0));
    checkOutput("rstMValid", 73'(mTvalid), 73'(0));
    checkOutput("rstMData", 73'(mTdata), 73'(0));
    checkOutput("rstMLast", 73'(mTlast), 73'(0));
    checkOutput("rstFrameErr", 73'(frameErr), 73'(0));
    @(negedge aclk);
    areset = 1'b0;
    repeat (2) @(negedge aclk);
    checkOutput("postRstSReady", 73'(sTready), 73'(1));

    // Basic frame with latency check on the first window
    b = winQ.size(); e = errPulses;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(DW'(i), i == 0);
      if (i == 10) begin
        checkOutput("latMValid", 73'(mTvalid), 73'(1));
        checkOutput("latMData", 73'(mTdata), 73'(72'h0a0908060504020100));
      end
    end
    drain(4);
    checkOutput("basicCount", 73'(winQ.size() - b), 73'(4));
    checkOutput("basicFirst", winQ[b], {1'b0, 72'h0a0908060504020100});
    checkOutput("basicLast", winQ[b + 3], {1'b1, 72'h0f0e0d0b0a09070605});
    checkWindows("basic", 0, b);
    checkOutput("basicErr", 73'(errPulses - e), 73'(0));

    // Backpressure after first window
    b = winQ.size(); e = errPulses;
    for (int i = 0; i < 11; i++) applyStimulus(DW'(i), i == 0);
    mTready = 1'b0;
    sTdata = 8'd11;
    sTvalid = 1'b1;
    repeat (5) begin
      @(negedge aclk);
      #1;
      checkOutput("bpSReady", 73'(sTready), 73'(0));
      checkOutput("bpMValid", 73'(mTvalid), 73'(1));
      checkOutput("bpMData", 73'(mTdata), 73'(72'h0a0908060504020100));
    end
    mTready = 1'b1;
    for (int i = 11; i < 16; i++) applyStimulus(DW'(i), 1'b0);
    drain(4);
    checkOutput("bpCount", 73'(winQ.size() - b), 73'(4));
    checkWindows("bp", 0, b);
    checkOutput("bpErr", 73'(errPulses - e), 73'(0));

    // Back-to-back frames
    b = winQ.size(); e = errPulses;
    sendFrame(0, 1'b1);
    sendFrame(100, 1'b1);
    drain(4);
    checkOutput("b2bCount", 73'(winQ.size() - b), 73'(8));
    checkOutput("b2bF2First", winQ[b + 4], {1'b0, 72'h6e6d6c6a6968666564});
    checkWindows("b2bF1", 0, b);
    checkWindows("b2bF2", 100, b + 4);
    checkOutput("b2bErr", 73'(errPulses - e), 73'(0));

    // Early SOF on pixel 6
    b = winQ.size(); e = errPulses;
    for (int i = 0; i < 6; i++) applyStimulus(DW'(i), i == 0);
    sendFrame(50, 1'b1);
    drain(4);
    checkOutput("sofErr", 73'(errPulses - e), 73'(1));
    checkOutput("sofCount", 73'(winQ.size() - b), 73'(4));
    checkWindows("sof", 50, b);

    // Missing SOF at the frame origin
    b = winQ.size(); e = errPulses;
    sendFrame(70, 1'b0);
    drain(4);
    checkOutput("noSofErr", 73'(errPulses - e), 73'(1));
    checkOutput("noSofCount", 73'(winQ.size() - b), 73'(4));
    checkWindows("noSof", 70, b);

    // Reset mid-frame
    for (int i = 0; i < 10; i++) applyStimulus(DW'(200 + i), i == 0);
    areset = 1'b1;
    #1;
    checkOutput("midRstMValid", 73'(mTvalid), 73'(0));
    checkOutput("midRstSReady", 73'(sTready), 73'(0));
    repeat (2) @(negedge aclk);
    areset = 1'b0;
    repeat (2) @(negedge aclk);
    b = winQ.size(); e = errPulses;
    sendFrame(20, 1'b1);
    drain(4);
    checkOutput("midRstCount", 73'(winQ.size() - b), 73'(4));
    checkWindows("midRst", 20, b);
    checkOutput("midRstErr", 73'(errPulses - e), 73'(0));

    // Random throttling over three frames
    b = winQ.size(); e = errPulses;
    rndMode = 1'b1;
    sendFrame(30, 1'b1);
    sendFrame(60, 1'b1);
    sendFrame(90, 1'b1);
    rndMode = 1'b0;
    drain(10);
    checkOutput("rndCount", 73'(winQ.size() - b), 73'(12));
    checkWindows("rndF1", 30, b);
    checkWindows("rndF2", 60, b + 4);
    checkWindows("rndF3", 90, b + 8);
    checkOutput("rndErr", 73'(errPulses - e), 73'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
